// File: rtl/peribus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : peribus_pkg                                            |
// | Description : Shared peribus definitions: bus widths used by the     |
// |               arbiter and the peripheral slaves, and the arbiter's   |
// |               sequencer state encoding.                              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package peribus_pkg;

   localparam int PERIBUS_ADDR_W = 2;
   localparam int PERIBUS_DATA_W = 16;

   // Sequencer states: one transaction walks IDLE -> ACCESS -> (RDWAIT) -> ACK.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RDWAIT = 2'd2,
      ACK    = 2'd3
   } peribus_state_t;

endpackage
`default_nettype wire

// File: rtl/peribus_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rr_pick                                                |
// | Description : Combinational round-robin picker. Returns the first    |
// |               set request at or above i_ptr, wrapping to index 0.    |
// | Ports       : i_req    - request vector                              |
// |               i_ptr    - index with highest priority                 |
// |               o_winner - index of the selected request               |
// |               o_valid  - at least one request is set                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module rr_pick #(
   parameter int NUM_REQ = 2,
   parameter int PTR_W   = 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PTR_W-1:0]   i_ptr,
   output logic [PTR_W-1:0]   o_winner,
   output logic               o_valid
);

   logic [PTR_W-1:0] w_hi;
   logic [PTR_W-1:0] w_lo;
   logic             w_hi_found;

   // Scan from the top down so the lowest qualifying index is written last.
   // w_hi tracks the lowest set request at/above the pointer, w_lo the
   // lowest set request overall (used when the search has to wrap).
   always_comb begin
      w_hi       = '0;
      w_lo       = '0;
      w_hi_found = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            if (PTR_W'(i) >= i_ptr) begin
               w_hi       = PTR_W'(i);
               w_hi_found = 1'b1;
            end
            w_lo = PTR_W'(i);
         end
      end
      o_winner = w_hi_found ? w_hi : w_lo;
      o_valid  = |i_req;
   end

endmodule
`default_nettype wire

// File: rtl/peribus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : peribus_arbiter                                        |
// | Description : Round-robin arbiter/sequencer sharing one peribus      |
// |               slave between NUM_REQ masters. One transaction at a    |
// |               time; write acks 2 cycles and read acks 3 cycles after |
// |               the request is sampled in IDLE.                        |
// | Ports       : clock, reset_n (async, active low)                     |
// |               req/req_we/req_addr/req_wdata - packed master requests |
// |               req_lock  - per-master bus lock (PERIBUS_ARB_LOCK_EN)  |
// |               ack/rdata - completion pulse and read data to masters  |
// |               grant/busy - bus owner (ACCESS..ACK), sequencer active |
// |               addr/write_data/write_en/read_en/chipselect/read_data  |
// |                         - slave-side peribus                         |
// | Options     : `define PERIBUS_ARB_LOCK_EN adds the req_lock port and |
// |               lets a master hold the bus over several transactions.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module peribus_arbiter
   import peribus_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = PERIBUS_ADDR_W,
   parameter int DATA_W  = PERIBUS_DATA_W
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
`ifdef PERIBUS_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]        req_lock,
`endif
   output logic [NUM_REQ-1:0]        ack,
   output logic [DATA_W-1:0]         rdata,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      busy,
   output logic [ADDR_W-1:0]         addr,
   output logic [DATA_W-1:0]         write_data,
   output logic                      write_en,
   output logic                      read_en,
   output logic                      chipselect,
   input  logic [DATA_W-1:0]         read_data
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam logic [NUM_REQ-1:0] c_one = {{(NUM_REQ-1){1'b0}}, 1'b1};

   peribus_state_t     r_state;
   peribus_state_t     w_state_next;
   logic [PTR_W-1:0]   r_ptr;
   logic [PTR_W-1:0]   r_win;
   logic               r_we;
   logic [ADDR_W-1:0]  r_addr;
   logic [DATA_W-1:0]  r_wdata;
   logic [DATA_W-1:0]  r_rdata;
   logic [NUM_REQ-1:0] w_win_oh;
   logic [NUM_REQ-1:0] w_req_eff;
   logic [PTR_W-1:0]   w_pick;
   logic               w_pick_valid;
   logic               w_ptr_hold;

   assign w_win_oh = c_one << r_win;

`ifdef PERIBUS_ARB_LOCK_EN
   logic r_lock;
   logic w_lock_hold;

   // The lock survives IDLE only while the owner keeps both req and
   // req_lock high; otherwise the full request vector competes this cycle.
   assign w_lock_hold = r_lock && req[r_win] && req_lock[r_win];
   assign w_req_eff   = w_lock_hold ? (req & w_win_oh) : req;
   assign w_ptr_hold  = req_lock[r_win];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_lock <= 1'b0;
      end else if (r_state == ACK) begin
         r_lock <= req_lock[r_win];
      end else if (r_state == IDLE && !w_lock_hold) begin
         r_lock <= 1'b0;
      end
   end
`else
   assign w_req_eff  = req;
   assign w_ptr_hold = 1'b0;
`endif

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_pick (
      .i_req    (w_req_eff),
      .i_ptr    (r_ptr),
      .o_winner (w_pick),
      .o_valid  (w_pick_valid)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      chipselect   = 1'b0;
      write_en     = 1'b0;
      read_en      = 1'b0;
      busy         = (r_state != IDLE);
      grant        = '0;
      ack          = '0;
      case (r_state)
         IDLE: begin
            if (w_pick_valid) begin
               w_state_next = ACCESS;
            end
         end
         ACCESS: begin
            chipselect   = 1'b1;
            write_en     = r_we;
            read_en      = !r_we;
            grant        = w_win_oh;
            w_state_next = r_we ? ACK : RDWAIT;
         end
         RDWAIT: begin
            grant        = w_win_oh;
            w_state_next = ACK;
         end
         ACK: begin
            grant        = w_win_oh;
            ack          = w_win_oh;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Transaction fields are latched once in IDLE; later changes on the
   // request inputs do not affect the transaction in flight.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_ptr   <= '0;
         r_win   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pick_valid) begin
                  r_win   <= w_pick;
                  r_we    <= req_we[w_pick];
                  r_addr  <= req_addr[w_pick*ADDR_W +: ADDR_W];
                  r_wdata <= req_wdata[w_pick*DATA_W +: DATA_W];
               end
            end
            RDWAIT: r_rdata <= read_data;
            ACK: begin
               if (!w_ptr_hold) begin
                  r_ptr <= (r_win == PTR_W'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Slave address/data simply mirror the latched fields, so they hold
   // their last values outside ACCESS.
   assign addr       = r_addr;
   assign write_data = r_wdata;
   assign rdata      = r_rdata;

endmodule
`default_nettype wire

// File: doc/peribus_arbiter.md
Name: peribus_arbiter

Overview:
Round-robin arbiter and sequencer that shares one peribus peripheral slave (e.g. Gpio) between NUM_REQ masters (CPU, DMA, debug).
- Accepts held-level requests and runs one bus transaction at a time.
- Generates chipselect/write_en/read_en pulses and captures read data.
- Returns read data with a one-cycle ack to the winning master.
- Sits between the masters and the slave's addr/write_data/write_en/read_en/chipselect/read_data port set.

Parameters:
NUM_REQ, 2, number of masters (2..4)
ADDR_W, 2, peribus address width
DATA_W, 16, peribus data width

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
req  input  NUM_REQ  per-master request level; held with fields until ack
req_we  input  NUM_REQ  per-master direction: 1 = write, 0 = read
req_addr  input  NUM_REQ*ADDR_W  packed per-master addresses; master i at [i*ADDR_W +: ADDR_W]
req_wdata  input  NUM_REQ*DATA_W  packed per-master write data
ack  output  NUM_REQ  one-cycle completion pulse to granted master
rdata  output  DATA_W  read data; valid only in the ack cycle
grant  output  NUM_REQ  one-hot owner of the bus, ACCESS through ACK
busy  output  1  high in any state other than IDLE
addr  output  ADDR_W  to slave
write_data  output  DATA_W  to slave
write_en  output  1  to slave, one-cycle pulse
read_en  output  1  to slave, one-cycle pulse
chipselect  output  1  to slave, high only in ACCESS
read_data  input  DATA_W  from slave; registered, valid the cycle after read_en

Behaviour:
- Reset (asynchronous, any state): state IDLE; ptr=0.
  - ack, grant, busy, write_en, read_en, chipselect = 0; addr, write_data, rdata = 0.
  - Any in-flight transaction is dropped and no ack is issued.
- FSM: IDLE, ACCESS, RDWAIT, ACK.
- IDLE: if any req is set, pick the winner as the first set req at or above ptr, wrapping modulo NUM_REQ.
  - Register the winner's index, we, addr and wdata; set grant; go to ACCESS.
  - If no req is set, stay in IDLE.
- ACCESS (1 cycle): chipselect=1, addr/write_data from the registered fields.
  - Exactly one of write_en/read_en = 1.
  - Next state: write -> ACK; read -> RDWAIT.
- RDWAIT (1 cycle): capture read_data into rdata; go to ACK.
- ACK (1 cycle): ack[winner]=1; rdata holds the captured value (holds the last read value on writes).
  - ptr = winner+1 mod NUM_REQ; go to IDLE.
- Latency from req sampled in IDLE (cycle 0): write ack at cycle 2, read ack at cycle 3. One transaction per 3 or 4 cycles.
- Masters must drop or replace req in the cycle after ack. req still high in the following IDLE is treated as a new request.
- Changing fields while req is high and before ack is legal; only the values sampled in IDLE are used.
- Requests arriving during a transaction wait; arbitration happens only in IDLE.
- Fairness: any continuously requesting master is granted within NUM_REQ transactions.
- Bus outputs addr/write_data hold their last values outside ACCESS; only the enables are zeroed.

Optional Feature:
Macro PERIBUS_ARB_LOCK_EN.
- Defined: adds input req_lock[NUM_REQ].
  - If req_lock[winner] is high in the ACK cycle, ptr is not advanced and a lock flag is set.
  - In IDLE with the lock set, only the locked master may win. Others wait even if requesting.
  - The lock clears in IDLE when the locked master's req or req_lock is low; normal round-robin resumes that same cycle.
  - Reset clears the lock.
- Undefined: no req_lock port, no lock flag; pure round-robin.

Decomposition:
- Package peribus_pkg: state enum (IDLE, ACCESS, RDWAIT, ACK), localparams PERIBUS_ADDR_W=2 and PERIBUS_DATA_W=16, shared with the Gpio slave.
- Sub-module rr_pick: combinational; inputs req and ptr; outputs winner index and a valid flag. Reused by future interrupt arbitration.

Test Plan:
- Single write: req=01, req_we=1, addr=2, wdata=16'hA5A5 -> cycle 1 chipselect=1, write_en=1, addr=2, write_data=A5A5; cycle 2 ack=01.
- Single read: master 1 reads addr=0, slave returns 16'h1234 the cycle after read_en -> ack=10 at cycle 3, rdata=1234.
- Contention: req=11 held for 4 transactions from ptr=0 -> grant order 01, 10, 01, 10; no master starved.
- Late request: master 1 raises req during master 0's ACCESS -> master 1 is granted in the next IDLE, ack has no gap beyond IDLE.
- Reset in RDWAIT: reset_n low mid-read -> all outputs 0 immediately, no ack; after release, ptr=0 and a new request completes normally.
- PERIBUS_ARB_LOCK_EN: master 0 locks with req=11 for 3 transactions -> grants 01, 01, 01; master 0 then drops req_lock -> next grant 10.
